pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard/sequencing controller for the 5-stage MIPS pipeline. Drives the stall/flush controls of IF/ID, ID/EX and EX/MEM.
//  Selects EX-stage operand forwarding.
//  Holds a multi-cycle MDU op (mult/div) in EX for MDU_LAT cycles via a small FSM + down-counter.
// PARAMETERS
//  MDU_LAT  4   EX occupancy of an MDU op in cycles (>=1; 1 = no hold)
//  CNT_W    32  width of perf counters (HAZARD_PERF_EN only)
// PORTS
//  clk_i            in   1  clock, rising edge
//  reset_ni         in   1  asynchronous reset, active-low
//  rs_id5, rt_id5   in   5  source regs of instr in ID
//  rs_ex5, rt_ex5   in   5  source regs of instr in EX
//  write_reg_ex5    in   5  dest reg in EX
//  enable_wreg_ex   in   1  EX instr writes RF
//  mem_to_reg_ex    in   1  EX instr is a load
//  write_reg_mem5   in   5  dest reg in MEM
//  enable_wreg_mem  in   1  MEM instr writes RF
//  write_reg_wb5    in   5  dest reg in WB
//  enable_wreg_wb   in   1  WB instr writes RF
//  pc_src_ex        in   1  taken branch/jump resolved in EX
//  mdu_start_ex     in   1  EX instr is an MDU op (held high while it sits in EX)
//  stall_if_o       out  1  hold PC
//  stall_id_o       out  1  hold IF/ID
//  stall_ex_o       out  1  hold ID/EX
//  flush_id_o       out  1  clear IF/ID
//  flush_ex_o       out  1  bubble into ID/EX
//  flush_mem_o      out  1  bubble into EX/MEM
//  fwd_a_ex2        out  2  ALU A source
//  fwd_b_ex2        out  2  ALU B source
//  mdu_busy_o       out  1  FSM in BUSY
// BEHAVIOUR
//  - Reset (reset_ni=0, async): FSM->IDLE, cnt->0, perf counters->0; every output 0 while reset is low.
//  - Forwarding (combinational): fwd_a=10 if enable_wreg_mem & write_reg_mem5!=0 & write_reg_mem5==rs_ex5;
//    else 01 if the same test holds with WB; else 00. B identical with rt_ex5. MEM has priority over WB.
//  - Load-use: lu = mem_to_reg_ex & enable_wreg_ex & write_reg_ex5!=0 & (write_reg_ex5==rs_id5 | write_reg_ex5==rt_id5).
//    lu -> stall_if_o=stall_id_o=flush_ex_o=1 for exactly 1 cycle.
//  - Branch: pc_src_ex -> flush_id_o=flush_ex_o=1; no stall from lu that cycle (the ID instr is squashed).
//  - MDU FSM states IDLE, BUSY:
//    - IDLE & mdu_start_ex & MDU_LAT>1: stall_if/id/ex=1, flush_mem_o=1, cnt<=MDU_LAT-2, ->BUSY.
//    - BUSY & cnt!=0: same stalls asserted, cnt<=cnt-1.
//    - BUSY & cnt==0: stalls low (instr leaves EX on this edge), ->IDLE.
//    - mdu_start_ex is ignored outside IDLE.
//    - MDU_LAT=1: FSM never leaves IDLE.
//    - Result: the MDU instr sits in EX for exactly MDU_LAT cycles; EX/MEM sees one valid copy.
//  - Simultaneous: MDU hold overrides lu (lu re-evaluated after release). pc_src_ex cannot coincide with an MDU op in EX.
//  - Reset mid-BUSY: immediate return to IDLE, stalls drop asynchronously.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds outputs stall_cycles_o[CNT_W], flush_count_o[CNT_W].
//    - stall_cycles_o counts cycles with stall_if_o=1.
//    - flush_count_o counts cycles with flush_id_o=1.
//    - Both saturate at all-ones.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  hazard_pkg: fwd_sel_e {FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}; mdu_state_e {IDLE, BUSY}; REG_ZERO=5'd0.
//  Sub-module hazard_mdu_seq: FSM + counter; outputs hold, busy.
//  Forwarding, load-use and flush logic stay in the top.
// TESTING
//  1. EX/MEM writes $8, EX rs=$8 -> fwd_a=10; MEM and WB both write $8 -> still 10; dest $0 -> 00.
//  2. lw $9 in EX, ID uses rt=$9 -> 1 cycle stall_if/id + flush_ex; next cycle all 0.
//  3. pc_src_ex=1 together with load-use -> flush_id=flush_ex=1, stall_if=0.
//  4. MDU_LAT=4, mdu_start_ex held -> stalls high 3 cycles, low on 4th, mdu_busy_o high cycles 2-4.
//  5. reset_ni pulsed low in BUSY -> outputs 0 at once; after release FSM IDLE, new start re-runs the full 4 cycles.
//  6. HAZARD_PERF_EN, CNT_W=4: 20 stall cycles -> stall_cycles_o=15 (saturated).

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and helpers for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // MEM is the younger producer, so it wins over WB
    function automatic fwd_sel_e fwd_select(
        input logic [4:0] src,
        input logic       en_mem,
        input logic [4:0] wr_mem,
        input logic       en_wb,
        input logic [4:0] wr_wb
    );
        if (en_mem && (wr_mem != REG_ZERO) && (wr_mem == src)) begin
            return FWD_MEM;
        end
        if (en_wb && (wr_wb != REG_ZERO) && (wr_wb == src)) begin
            return FWD_WB;
        end
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_mdu_seq.sv
// rtl/hazard_mdu_seq.sv - holds a multi-cycle MDU op in EX for MDU_LAT cycles
module hazard_mdu_seq
    import hazard_pkg::*;
#(
    parameter int MDU_LAT = 4
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic start,
    output logic hold,
    output logic busy
);

    localparam int CW = (MDU_LAT > 2) ? $clog2(MDU_LAT - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = (MDU_LAT > 2) ? CW'(MDU_LAT - 2) : '0;

    mdu_state_e    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The first EX cycle is spent in IDLE, so BUSY only covers the remaining ones
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hold      = 1'b0;
        case (state)
            IDLE: begin
                if (start && (MDU_LAT > 1)) begin
                    hold      = 1'b1;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    hold    = 1'b1;
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline stall/flush/forwarding control; HAZARD_PERF_EN adds perf counters
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_LAT = 4
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W   = 32
`endif
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [4:0]       rs_id5,
    input  logic [4:0]       rt_id5,
    input  logic [4:0]       rs_ex5,
    input  logic [4:0]       rt_ex5,
    input  logic [4:0]       write_reg_ex5,
    input  logic             enable_wreg_ex,
    input  logic             mem_to_reg_ex,
    input  logic [4:0]       write_reg_mem5,
    input  logic             enable_wreg_mem,
    input  logic [4:0]       write_reg_wb5,
    input  logic             enable_wreg_wb,
    input  logic             pc_src_ex,
    input  logic             mdu_start_ex,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             stall_ex_o,
    output logic             flush_id_o,
    output logic             flush_ex_o,
    output logic             flush_mem_o,
    output logic [1:0]       fwd_a_ex2,
    output logic [1:0]       fwd_b_ex2,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o,
`endif
    output logic             mdu_busy_o
);

    logic     mdu_hold, mdu_busy;
    logic     load_use, lu_stall;
    logic     stall_front, flush_ex;
    fwd_sel_e fwd_a, fwd_b;

    hazard_mdu_seq #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu_seq (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .start    (mdu_start_ex),
        .hold     (mdu_hold),
        .busy     (mdu_busy)
    );

    assign fwd_a = fwd_select(rs_ex5, enable_wreg_mem, write_reg_mem5, enable_wreg_wb, write_reg_wb5);
    assign fwd_b = fwd_select(rt_ex5, enable_wreg_mem, write_reg_mem5, enable_wreg_wb, write_reg_wb5);

    assign load_use = mem_to_reg_ex && enable_wreg_ex && (write_reg_ex5 != REG_ZERO) &&
                      ((write_reg_ex5 == rs_id5) || (write_reg_ex5 == rt_id5));

    // A taken branch squashes the dependent ID instr; an MDU hold freezes ID/EX anyway
    assign lu_stall    = load_use && !pc_src_ex && !mdu_hold;
    assign stall_front = mdu_hold || lu_stall;
    assign flush_ex    = pc_src_ex || lu_stall;

    // Outputs are forced low combinationally so they drop the instant reset asserts
    assign stall_if_o  = reset_ni && stall_front;
    assign stall_id_o  = reset_ni && stall_front;
    assign stall_ex_o  = reset_ni && mdu_hold;
    assign flush_id_o  = reset_ni && pc_src_ex;
    assign flush_ex_o  = reset_ni && flush_ex;
    assign flush_mem_o = reset_ni && mdu_hold;
    assign fwd_a_ex2   = reset_ni ? fwd_a : FWD_NONE;
    assign fwd_b_ex2   = reset_ni ? fwd_b : FWD_NONE;
    assign mdu_busy_o  = reset_ni && mdu_busy;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_front && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (pc_src_ex && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cycles_o = stall_cnt;
    assign flush_count_o  = flush_cnt;
`endif

endmodule
